// File: rtl/sb_transaction_tx.sv
`default_nettype none
// ============================================================================
// Module      : sb_transaction_tx
// Description : Sideband transaction transmitter. Serialises AT requests
//               (read/write, address, 24-bit payload) and LT requests (LSE
//               symbol) into framed sideband symbols with DLE/STX/ETX framing,
//               CRC-16 (poly 0x8005, MSB-first) and DLE byte stuffing.
// Ports       : sb_clk      - sideband clock, rising edge
//               rst         - asynchronous active-low reset
//               at_start    - AT request (taken only when idle and not busy)
//               at_cmd      - 1 = command STX, 0 = response STX
//               s_write     - 1 = write (payload sent), 0 = read
//               s_address   - register address
//               payload_out - write data, MSB byte first
//               lt_start    - LT request (priority over at_start)
//               lse         - LSE symbol for LT
//               tdisconnect - abort current frame and hold idle
//               sbtx        - {stop=1, byte, start=0}; 10'h3FF when idle
//               tx_en       - sbtx carries a valid symbol
//               tx_busy     - frame in progress
//               tx_done     - pulse on the last symbol of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module sb_transaction_tx #(
    parameter logic [7:0]  DLE_SYMBOL = 8'hFE,
    parameter logic [7:0]  STX_CMD    = 8'hA0,
    parameter logic [7:0]  STX_RSP    = 8'h20,
    parameter logic [7:0]  ETX_SYMBOL = 8'h40,
    parameter logic [15:0] CRC_INIT   = 16'hFFFF
) (
    input  logic        sb_clk,
    input  logic        rst,
    input  logic        at_start,
    input  logic        at_cmd,
    input  logic        s_write,
    input  logic [7:0]  s_address,
    input  logic [23:0] payload_out,
    input  logic        lt_start,
    input  logic [7:0]  lse,
    input  logic        tdisconnect,
    output logic [9:0]  sbtx,
    output logic        tx_en,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam logic [9:0]  c_IDLE_SYM = 10'h3FF;
    localparam logic [15:0] c_POLY     = 16'h8005;

    // Each state names the symbol that will be registered onto sbtx at the
    // next clock edge.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_AT_DLE   = 4'd1,
        S_AT_STX   = 4'd2,
        S_AT_ADDR  = 4'd3,
        S_AT_LEN   = 4'd4,
        S_AT_DATA  = 4'd5,
        S_AT_CRC   = 4'd6,
        S_AT_DLE_E = 4'd7,
        S_AT_ETX   = 4'd8,
        S_STUFF    = 4'd9,
        S_LT_DLE   = 4'd10,
        S_LT_LSE   = 4'd11,
        S_LT_CLSE  = 4'd12
    } state_t;

    state_t      r_state, r_ret_state, w_next_state, w_ret_state;
    logic [1:0]  r_idx, w_next_idx;
    logic [15:0] r_crc;
    logic        r_cmd, r_write;
    logic [7:0]  r_addr, r_lse;
    logic [23:0] r_payload;
    logic [9:0]  r_sbtx;
    logic        r_tx_en, r_tx_busy, r_tx_done;

    logic        w_accept_at, w_accept_lt;
    logic [7:0]  w_byte;
    logic        w_en, w_done, w_crc_en, w_stuff_chk, w_stuff;

    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc,
                                                 input logic [7:0]  data);
        logic [15:0] v;
        logic        fb;
        v = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = v[15] ^ data[i];
            v  = {v[14:0], 1'b0};
            if (fb) v = v ^ c_POLY;
        end
        return v;
    endfunction

    always_comb begin
        w_next_state = r_state;
        w_ret_state  = r_ret_state;
        w_next_idx   = r_idx;
        w_byte       = 8'h00;
        w_en         = 1'b0;
        w_done       = 1'b0;
        w_crc_en     = 1'b0;
        w_stuff_chk  = 1'b0;
        w_stuff      = 1'b0;
        w_accept_at  = 1'b0;
        w_accept_lt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // r_tx_busy still high means the last symbol is on the wire;
                // waiting one more cycle guarantees an idle gap.
                if (!r_tx_busy) begin
                    if (lt_start) begin
                        w_accept_lt  = 1'b1;
                        w_next_state = S_LT_DLE;
                    end else if (at_start) begin
                        w_accept_at  = 1'b1;
                        w_next_state = S_AT_DLE;
                    end
                end
                w_next_idx = 2'd0;
            end
            S_AT_DLE: begin
                w_byte = DLE_SYMBOL; w_en = 1'b1;
                w_next_state = S_AT_STX;
            end
            S_AT_STX: begin
                w_byte = r_cmd ? STX_CMD : STX_RSP; w_en = 1'b1; w_crc_en = 1'b1;
                w_next_state = S_AT_ADDR;
            end
            S_AT_ADDR: begin
                w_byte = r_addr; w_en = 1'b1; w_crc_en = 1'b1; w_stuff_chk = 1'b1;
                w_next_state = S_AT_LEN;
            end
            S_AT_LEN: begin
                w_byte = {r_write, 7'd3}; w_en = 1'b1; w_crc_en = 1'b1; w_stuff_chk = 1'b1;
                w_next_state = r_write ? S_AT_DATA : S_AT_CRC;
                w_next_idx   = 2'd0;
            end
            S_AT_DATA: begin
                case (r_idx)
                    2'd0:    w_byte = r_payload[23:16];
                    2'd1:    w_byte = r_payload[15:8];
                    default: w_byte = r_payload[7:0];
                endcase
                w_en = 1'b1; w_crc_en = 1'b1; w_stuff_chk = 1'b1;
                if (r_idx == 2'd2) begin
                    w_next_state = S_AT_CRC;
                    w_next_idx   = 2'd0;
                end else begin
                    w_next_idx   = r_idx + 2'd1;
                end
            end
            S_AT_CRC: begin
                w_byte = (r_idx == 2'd0) ? r_crc[15:8] : r_crc[7:0];
                w_en = 1'b1; w_stuff_chk = 1'b1;
                if (r_idx == 2'd1) begin
                    w_next_state = S_AT_DLE_E;
                    w_next_idx   = 2'd0;
                end else begin
                    w_next_idx   = r_idx + 2'd1;
                end
            end
            S_AT_DLE_E: begin
                w_byte = DLE_SYMBOL; w_en = 1'b1;
                w_next_state = S_AT_ETX;
            end
            S_AT_ETX: begin
                w_byte = ETX_SYMBOL; w_en = 1'b1; w_done = 1'b1;
                w_next_state = S_IDLE;
            end
            S_STUFF: begin
                w_byte = DLE_SYMBOL; w_en = 1'b1;
                w_next_state = r_ret_state;
            end
            S_LT_DLE: begin
                w_byte = DLE_SYMBOL; w_en = 1'b1;
                w_next_state = S_LT_LSE;
            end
            S_LT_LSE: begin
                w_byte = r_lse; w_en = 1'b1;
                w_next_state = S_LT_CLSE;
            end
            S_LT_CLSE: begin
                w_byte = ~r_lse; w_en = 1'b1; w_done = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_idx   = 2'd0;
            end
        endcase

        // A DLE-valued data byte gets an extra DLE; remember where to resume.
        if (w_stuff_chk && (w_byte == DLE_SYMBOL)) begin
            w_stuff      = 1'b1;
            w_ret_state  = w_next_state;
            w_next_state = S_STUFF;
        end

        // Disconnect drops the frame outright, suppressing the symbol too.
        if (tdisconnect) begin
            w_next_state = S_IDLE;
            w_next_idx   = 2'd0;
            w_en         = 1'b0;
            w_done       = 1'b0;
            w_crc_en     = 1'b0;
            w_stuff      = 1'b0;
            w_accept_at  = 1'b0;
            w_accept_lt  = 1'b0;
        end
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ret_state <= S_IDLE;
            r_idx       <= 2'd0;
            r_crc       <= CRC_INIT;
            r_cmd       <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 8'h00;
            r_payload   <= 24'h000000;
            r_lse       <= 8'h00;
            r_sbtx      <= c_IDLE_SYM;
            r_tx_en     <= 1'b0;
            r_tx_busy   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_idx     <= w_next_idx;
            if (w_stuff) r_ret_state <= w_ret_state;

            if (w_accept_at) begin
                r_cmd     <= at_cmd;
                r_write   <= s_write;
                r_addr    <= s_address;
                r_payload <= payload_out;
            end
            if (w_accept_lt) r_lse <= lse;

            if (w_accept_at || w_accept_lt) r_crc <= CRC_INIT;
            else if (w_crc_en)              r_crc <= f_crc16_byte(r_crc, w_byte);

            r_sbtx    <= w_en ? {1'b1, w_byte, 1'b0} : c_IDLE_SYM;
            r_tx_en   <= w_en;
            r_tx_busy <= w_en;
            r_tx_done <= w_done;
        end
    end

    assign sbtx    = r_sbtx;
    assign tx_en   = r_tx_en;
    assign tx_busy = r_tx_busy;
    assign tx_done = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_sb_transaction_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_transaction_tx
// Description : Directed self-checking bench for sb_transaction_tx. Frames
//               are captured from sbtx and compared with byte sequences built
//               by an independent CRC/stuffing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_transaction_tx;

    logic        sb_clk = 1'b0;
    logic        rst    = 1'b0;
    logic        at_start = 1'b0, at_cmd = 1'b0, s_write = 1'b0;
    logic [7:0]  s_address = 8'h00;
    logic [23:0] payload_out = 24'h0;
    logic        lt_start = 1'b0;
    logic [7:0]  lse = 8'h00;
    logic        tdisconnect = 1'b0;
    logic [9:0]  sbtx;
    logic        tx_en, tx_busy, tx_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    sb_transaction_tx dut (
        .sb_clk      (sb_clk),
        .rst         (rst),
        .at_start    (at_start),
        .at_cmd      (at_cmd),
        .s_write     (s_write),
        .s_address   (s_address),
        .payload_out (payload_out),
        .lt_start    (lt_start),
        .lse         (lse),
        .tdisconnect (tdisconnect),
        .sbtx        (sbtx),
        .tx_en       (tx_en),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 sb_clk = ~sb_clk;

    task automatic tick();
        @(posedge sb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // CRC-16/0x8005 reference: byte XORed into the top, then 8 shifts.
    function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] v;
        v = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++)
            v = v[15] ? ((v << 1) ^ 16'h8005) : (v << 1);
        return v;
    endfunction

    task automatic push_stuffed(input logic [7:0] b);
        exp_q.push_back(b);
        if (b == 8'hFE) exp_q.push_back(8'hFE);
    endtask

    task automatic build_at(input logic cmd, input logic wr, input logic [7:0] a,
                            input logic [23:0] p);
        logic [15:0] c;
        logic [7:0]  stx, len;
        stx = cmd ? 8'hA0 : 8'h20;
        len = {wr, 7'd3};
        exp_q = {};
        exp_q.push_back(8'hFE);
        exp_q.push_back(stx);
        c = model_crc(16'hFFFF, stx);
        push_stuffed(a);   c = model_crc(c, a);
        push_stuffed(len); c = model_crc(c, len);
        if (wr) begin
            push_stuffed(p[23:16]); c = model_crc(c, p[23:16]);
            push_stuffed(p[15:8]);  c = model_crc(c, p[15:8]);
            push_stuffed(p[7:0]);   c = model_crc(c, p[7:0]);
        end
        push_stuffed(c[15:8]);
        push_stuffed(c[7:0]);
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'h40);
    endtask

    // Presents an AT request for one edge, then scrambles the request inputs.
    task automatic start_at(input logic cmd, input logic wr, input logic [7:0] a,
                            input logic [23:0] p);
        at_start = 1'b1; at_cmd = cmd; s_write = wr; s_address = a; payload_out = p;
        tick();
        at_start = 1'b0; at_cmd = ~cmd; s_write = ~wr; s_address = ~a; payload_out = ~p;
    endtask

    // Captures one frame after the accepting edge and compares it with exp_q.
    task automatic collect(input string tag, input int lt_pulse_at);
        int first = -1, done_at = -1, bad = 0, ended = 0;
        logic pulsing = 1'b0;
        logic [7:0] g;
        got_q = {};
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (pulsing) begin lt_start = 1'b0; pulsing = 1'b0; end
            if (tx_en === 1'b1) begin
                if (first < 0) first = c;
                got_q.push_back(sbtx[8:1]);
                if (sbtx[9] !== 1'b1 || sbtx[0] !== 1'b0 || tx_busy !== 1'b1) bad++;
                if (tx_done === 1'b1) begin
                    if (done_at >= 0) bad++;
                    done_at = got_q.size();
                end
                if (got_q.size() == lt_pulse_at) begin lt_start = 1'b1; pulsing = 1'b1; end
            end else begin
                if (tx_done !== 1'b0) bad++;
                if (got_q.size() > 0) begin ended = 1; break; end
            end
        end
        check({tag, "_ended"}, ended, 1);
        check({tag, "_latency"}, first, 1);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), {24'h0, g}, {24'h0, exp_q[i]});
        end
        check({tag, "_done_pos"}, done_at, exp_q.size());
        check({tag, "_framing_busy"}, bad, 0);
        check({tag, "_post_busy"}, tx_busy, 1'b0);
        check({tag, "_post_sbtx"}, sbtx, 10'h3FF);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx_en !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int n, done_seen, got;

        // Reset state
        #12;
        check("reset_sbtx",  sbtx,    10'h3FF);
        check("reset_tx_en", tx_en,   1'b0);
        check("reset_busy",  tx_busy, 1'b0);
        check("reset_done",  tx_done, 1'b0);
        @(negedge sb_clk); rst = 1'b1;
        tick(); tick();

        // AT write command; an LT pulse in mid-frame must be dropped
        build_at(1'b1, 1'b1, 8'h12, 24'h345678);
        start_at(1'b1, 1'b1, 8'h12, 24'h345678);
        collect("wr", 3);
        check("wr_fixed_hdr", {exp_q[0], exp_q[1], exp_q[2], exp_q[3]}, 32'hFEA01283);
        expect_quiet("busy_pulse_dropped", 5);

        // AT read response
        build_at(1'b0, 1'b0, 8'h05, 24'hABCDEF);
        start_at(1'b0, 1'b0, 8'h05, 24'hABCDEF);
        collect("rd", 0);
        check("rd_symbols", got_q.size(), 8);
        tick();

        // Stuffing in address and payload
        build_at(1'b1, 1'b1, 8'hFE, 24'hFE0001);
        start_at(1'b1, 1'b1, 8'hFE, 24'hFE0001);
        collect("stuff", 0);
        check("stuff_prefix", {exp_q[2], exp_q[3], exp_q[4], exp_q[5]}, 32'hFEFE83FE);
        tick();

        // LT has priority over a simultaneous AT request
        exp_q = '{8'hFE, 8'h02, 8'hFD};
        lt_start = 1'b1; lse = 8'h02; at_start = 1'b1; at_cmd = 1'b1; s_write = 1'b1;
        tick();
        lt_start = 1'b0; at_start = 1'b0; lse = 8'h55;
        collect("lt", 0);
        tick();

        // Disconnect on the 5th symbol of a write
        start_at(1'b1, 1'b1, 8'h11, 24'h223344);
        n = 0; done_seen = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            tick();
            if (tx_en === 1'b1) n++;
            if (tx_done === 1'b1) done_seen++;
        end
        check("disc_reached_sym5", n, 5);
        tdisconnect = 1'b1; at_start = 1'b1;
        tick();
        if (tx_done === 1'b1) done_seen++;
        tick();
        check("disc_tx_en",   tx_en,   1'b0);
        check("disc_tx_busy", tx_busy, 1'b0);
        check("disc_sbtx",    sbtx,    10'h3FF);
        tdisconnect = 1'b0; at_start = 1'b0;
        expect_quiet("disc_quiet", 3);
        check("disc_no_done", done_seen, 0);
        build_at(1'b1, 1'b1, 8'h3C, 24'h00FF10);
        start_at(1'b1, 1'b1, 8'h3C, 24'h00FF10);
        collect("after_disc", 0);
        tick();

        // Reset pulled low mid-frame
        start_at(1'b1, 1'b1, 8'h77, 24'h123456);
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            tick();
            if (tx_en === 1'b1) got++;
        end
        #2 rst = 1'b0;
        #1;
        check("mrst_sbtx",  sbtx,    10'h3FF);
        check("mrst_tx_en", tx_en,   1'b0);
        check("mrst_busy",  tx_busy, 1'b0);
        check("mrst_done",  tx_done, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        build_at(1'b1, 1'b1, 8'h12, 24'h345678);
        start_at(1'b1, 1'b1, 8'h12, 24'h345678);
        collect("post_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sb_transaction_tx.md
# sb_transaction_tx

Sideband transaction transmitter: the transmit-side counterpart of the SB transaction receiver. It takes an AT request (read/write, address, 24-bit payload) or an LT request (LSE symbol) from the control unit and serialises it onto sbtx as framed bytes. It handles:
- the DLE/STX/ETX framing,
- CRC-16 generation,
- DLE byte stuffing.

It sits between the control unit and the sideband serializer, sharing sb_clk with the receive FSM.

## Interface
Parameters:
- DLE_SYMBOL, 8'hFE: frame escape symbol.
- STX_CMD, 8'hA0: STX for AT command.
- STX_RSP, 8'h20: STX for AT response.
- ETX_SYMBOL, 8'h40: end-of-frame symbol.
- CRC_INIT, 16'hFFFF: CRC seed.

Ports:
- sb_clk  in  1  sideband clock; single clock domain, rising edge.
- rst  in  1  asynchronous, active-low reset.
- at_start  in  1  AT request; accepted only when tx_busy=0.
- at_cmd  in  1  1 = command (STX_CMD), 0 = response (STX_RSP).
- s_write  in  1  1 = write (payload sent), 0 = read (no payload).
- s_address  in  8  register address.
- payload_out  in  24  write data; sent MSB byte first.
- lt_start  in  1  LT request; accepted only when tx_busy=0.
- lse  in  8  LSE symbol for LT.
- tdisconnect  in  1  abort and hold idle.
- sbtx  out  10  framed symbol: {1'b1 stop, byte[7:0], 1'b0 start}.
- tx_en  out  1  sbtx carries a valid symbol this cycle.
- tx_busy  out  1  transaction in progress.
- tx_done  out  1  one-cycle pulse on the last symbol of a frame.

## Operation
- FSM states:
  - IDLE
  - AT_DLE, AT_STX, AT_ADDR, AT_LEN, AT_DATA, AT_CRC, AT_DLE_E, AT_ETX
  - STUFF
  - LT_DLE, LT_LSE, LT_CLSE
- Acceptance:
  - In IDLE with tdisconnect=0, lt_start has priority over at_start when both are high.
  - All request inputs are captured into internal registers at acceptance; later changes to them are ignored.
- AT symbol order:
  - DLE, STX, address, len byte, payload[23:16], payload[15:8], payload[7:0], CRC[15:8], CRC[7:0], DLE, ETX.
  - len byte = {s_write, 7'd3}.
  - Read (s_write=0) skips the three payload symbols.
- LT symbol order: DLE, lse, ~lse. No CRC, no stuffing.
- CRC-16:
  - Polynomial 0x8005 (x^16+x^15+x^2+1), seed CRC_INIT, MSB-first, no final XOR.
  - Covers STX, address, len and payload bytes, using unstuffed values.
  - Updated one byte per symbol as each covered byte is emitted.
- Stuffing:
  - Any address, len, payload or CRC byte equal to DLE_SYMBOL is followed by an extra DLE_SYMBOL.
  - The FSM enters STUFF for that extra cycle, then resumes at the next byte.
  - Stuffed DLEs are not fed into the CRC.
- Byte index counter (2-bit) steps through the payload and CRC bytes; it is cleared on entry to each multi-byte state.
- tdisconnect, in any state:
  - The next state is IDLE and the frame is dropped; tx_done is not asserted.
  - Requests are ignored while tdisconnect=1.

## Timing
- Reset values, with rst low asynchronously forcing all of them:
  - FSM state IDLE
  - sbtx = 10'h3FF
  - tx_en = 0, tx_busy = 0, tx_done = 0
  - CRC register = CRC_INIT, byte counter = 0
- All outputs are registered.
- A request accepted at edge N drives the first DLE on sbtx with tx_en=1 after edge N+1. Symbols follow back-to-back, one per cycle, with no gaps.
- tx_busy:
  - High from the first symbol through the last symbol inclusive.
  - Low in the cycle after the last symbol, so the minimum inter-frame gap is one idle cycle.
- tx_done is high in the same cycle as the ETX (AT) or ~lse (LT) symbol.
- Symbol counts without stuffing:
  - AT write: 11 symbols.
  - AT read: 8 symbols.
  - LT: 3 symbols.
  - Each stuffed byte adds one symbol.
- Whenever tx_en=0, sbtx = 10'h3FF.
- Abort on tdisconnect: if tdisconnect is high at edge M, tx_en=0 and tx_busy=0 after edge M+1.
- Reset mid-frame: outputs return to their reset values immediately; after release, the next frame starts cleanly with the CRC re-seeded.
- A start pulse asserted while tx_busy=1 is dropped; it is not queued.

## Test plan
- AT write command, addr 0x12, payload 0x345678:
  - Bytes FE A0 12 83 34 56 78 c1 c0 FE 40, where c1/c0 come from the CRC model.
  - tx_done on the 11th symbol; tx_busy low on the following cycle.
- AT read response, addr 0x05 -> bytes FE 20 05 03 c1 c0 FE 40, 8 symbols.
- Stuffing: write, addr 0xFE, payload 0xFE0001:
  - Bytes FE A0 FE FE 83 FE FE 00 01 then CRC, stuffed if either CRC byte is FE, then FE 40.
  - CRC equals the model computed over A0 FE 83 FE 00 01.
- LT with lse=0x02 -> bytes FE 02 FD, tx_done on FD. With lt_start and at_start high together, only the LT frame is sent.
- tdisconnect asserted on the 5th symbol of a write:
  - tx_en=0 and tx_busy=0 next cycle, with no tx_done.
  - A new at_start after tdisconnect drops produces a full, correct frame.
- rst pulled low mid-frame:
  - Outputs take their reset values asynchronously: sbtx=3FF, tx_en=0, tx_busy=0, tx_done=0.
  - A post-reset write reproduces the first scenario's CRC exactly.
